cordic_dispatch: RTL

Request-queuing front end for the CORDIC core. Accepts CORDIC jobs over a valid/ready interface, buffers them in a small FIFO, issues them one at a time to the core as a single-cycle `valid` pulse, waits for the core's `done`, and presents each result on a valid/ready response port. A watchdog converts a missing `done` into a flagged timeout response so the pipeline never hangs. Types `cordic_func` and `cordic_data` come from `cordic_wrapper_pkg`.

---
 rtl/cordic_wrapper_pkg.sv | 19 +
 rtl/cordic_dispatch_if.sv | 47 ++++
 rtl/cordic_dispatch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cordic_wrapper_pkg.sv
// Shared CORDIC job types.
//   cordic_func : operation selector carried with every job and response
//   cordic_data : packed x/y/z operand / result triple
package cordic_wrapper_pkg;

    typedef enum logic [1:0] {
        FUNC_ROTATE = 2'd0,
        FUNC_VECTOR = 2'd1,
        FUNC_SINCOS = 2'd2,
        FUNC_ATAN   = 2'd3
    } cordic_func;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } cordic_data;

endpackage

// File: rtl/cordic_dispatch_if.sv
// Bundle of all cordic_dispatch handshake/bus signals.
//   req_*    : upstream job request (valid/ready)
//   cordic_* : issue pulse to the core and its done/result return
//   rsp_*    : downstream response (valid/ready) plus timeout flag
//   o_busy, o_count : status
// Signal names keep the i_/o_ prefixes as seen from the dispatcher.
// slave  : the dispatcher itself
// master : whatever surrounds it (upstream, core, downstream)
interface cordic_dispatch_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                                  i_req_valid;
    logic                                  o_req_ready;
    cordic_wrapper_pkg::cordic_func        i_req_func;
    cordic_wrapper_pkg::cordic_data        i_req_data;

    logic                                  o_cordic_valid;
    cordic_wrapper_pkg::cordic_func        o_cordic_func;
    cordic_wrapper_pkg::cordic_data        o_cordic_data;
    logic                                  i_cordic_done;
    cordic_wrapper_pkg::cordic_data        i_cordic_data;

    logic                                  o_rsp_valid;
    logic                                  i_rsp_ready;
    cordic_wrapper_pkg::cordic_func        o_rsp_func;
    cordic_wrapper_pkg::cordic_data        o_rsp_data;
    logic                                  o_rsp_timeout;

    logic                                  o_busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0]       o_count;

    modport slave (
        input  i_req_valid, i_req_func, i_req_data,
        input  i_cordic_done, i_cordic_data, i_rsp_ready,
        output o_req_ready, o_cordic_valid, o_cordic_func, o_cordic_data,
        output o_rsp_valid, o_rsp_func, o_rsp_data, o_rsp_timeout,
        output o_busy, o_count
    );

    modport master (
        output i_req_valid, i_req_func, i_req_data,
        output i_cordic_done, i_cordic_data, i_rsp_ready,
        input  o_req_ready, o_cordic_valid, o_cordic_func, o_cordic_data,
        input  o_rsp_valid, o_rsp_func, o_rsp_data, o_rsp_timeout,
        input  o_busy, o_count
    );
endinterface

// File: rtl/cordic_dispatch.sv
// Request-queuing front end for the CORDIC core.
// Jobs are buffered in a FIFO, issued one at a time as a single-cycle pulse,
// and the core's result (or a watchdog timeout) is held on the response port
// until accepted.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : cordic_dispatch_if.slave (request, core, response, status)
module cordic_dispatch
    import cordic_wrapper_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    cordic_dispatch_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t             state;
    cordic_func         fifo_func [FIFO_DEPTH];
    cordic_data         fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [WD_W-1:0]    wd;
    logic [WD_W-1:0]    wd_next;
    cordic_func         rsp_func;
    cordic_data         rsp_data;
    logic               rsp_timeout;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.i_req_valid && !full;
    // ISSUE is only entered with a non-empty FIFO, so the pop is always legal.
    assign pop     = (state == S_ISSUE);
    assign wd_next = wd + 1'b1;

    // Storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_func[wr_ptr] <= bus.i_req_func;
            fifo_data[wr_ptr] <= bus.i_req_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wd          <= '0;
            rsp_func    <= cordic_func'(0);
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    rsp_func <= fifo_func[rd_ptr];
                    wd       <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd_next;
                    // A done arriving on the expiry cycle still counts as a result.
                    if (bus.i_cordic_done) begin
                        rsp_data    <= bus.i_cordic_data;
                        rsp_timeout <= 1'b0;
                        state       <= S_HOLD;
                    end else if (wd_next == WD_W'(TIMEOUT_CYCLES)) begin
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.i_rsp_ready) state <= empty ? S_IDLE : S_ISSUE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_ready    = !full;
    assign bus.o_cordic_valid = (state == S_ISSUE);
    assign bus.o_cordic_func  = fifo_func[rd_ptr];
    assign bus.o_cordic_data  = fifo_data[rd_ptr];
    assign bus.o_rsp_valid    = (state == S_HOLD);
    assign bus.o_rsp_func     = rsp_func;
    assign bus.o_rsp_data     = rsp_data;
    assign bus.o_rsp_timeout  = rsp_timeout;
    assign bus.o_busy         = (state != S_IDLE) || !empty;
    assign bus.o_count        = count;

endmodule
